// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction fetch/prefetch unit.
package ifetch_pkg;

  // Default datapath widths for the 16-bit family.
  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  // IDLE: nothing outstanding, REQ: fetching fetch_pc, DROP: stale fetch in flight.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Prefetch queue entry layout at the default widths.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } q_entry_t;

endpackage

// File: rtl/instruction_fetch_prefetch_if.sv
// Memory port, redirect and decode handshake bundle of the fetch unit.
interface instruction_fetch_prefetch_if #(
  parameter int INSTR_W = ifetch_pkg::INSTR_W,
  parameter int PC_W    = ifetch_pkg::PC_W
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    fetch_pc;

  // The fetch unit itself.
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  // Memory, branch unit and decode seen together as the environment.
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/ifetch_queue.sv
// Small FIFO with flush, simultaneous push/pop and an occupancy count.
// The head is read combinationally so decode sees it without a bubble.
module ifetch_queue #(
  parameter int QDEPTH  = 4,
  parameter int ENTRY_W = 32,
  localparam int AW     = $clog2(QDEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [AW:0]        count_o
);

  logic [ENTRY_W-1:0] mem_q [QDEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;
  logic               push_ok;
  logic               pop_ok;

  // A pop frees the slot a same-cycle push may need when the queue is full.
  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !flush_i && !empty_o;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(QDEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap as QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_prefetch.sv
// Sequential instruction fetch with a prefetch queue and redirect flush.
// Queue credits are reserved when a request issues, so a response always has a slot.
module instruction_fetch_prefetch #(
  parameter int                     INSTR_W  = ifetch_pkg::INSTR_W,
  parameter int                     PC_W     = ifetch_pkg::PC_W,
  parameter int                     QDEPTH   = 4,
  parameter logic [PC_W-1:0]        RESET_PC = '0,
  parameter int unsigned            PC_STEP  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  instruction_fetch_prefetch_if.master  bus
);

  import ifetch_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e    state_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic            imem_req_q;
  logic [PC_W-1:0] imem_addr_q;

  logic            ack;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] fetch_pc_inc;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   count_after;
  logic            q_empty;
  logic            q_full;
  logic            credit_idle;
  logic            credit_after;
  entry_t          q_wdata;
  entry_t          q_rdata;

  // Acks are meaningful only while a request is actually on the port.
  assign ack          = imem_req_q && bus.imem_ack;
  assign push         = (state_q == REQ) && ack && !bus.redirect_valid;
  assign pop          = bus.out_ready && !q_empty && !bus.redirect_valid;
  assign fetch_pc_inc = fetch_pc_q + PC_W'(PC_STEP);
  assign count_after  = q_count + CW'(push) - CW'(pop);
  // With nothing outstanding the credit test reduces to "queue not full".
  assign credit_idle  = !q_full;
  assign credit_after = (count_after < CW'(QDEPTH));
  assign q_wdata      = '{pc: fetch_pc_q, instr: bus.imem_rdata};

  ifetch_queue #(
    .QDEPTH  (QDEPTH),
    .ENTRY_W ($bits(entry_t))
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (bus.redirect_valid),
    .push_i  (push),
    .wdata_i (q_wdata),
    .pop_i   (pop),
    .rdata_o (q_rdata),
    .empty_o (q_empty),
    .full_o  (q_full),
    .count_o (q_count)
  );

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.fetch_pc  = fetch_pc_q;
  assign bus.out_valid = !q_empty;
  assign bus.out_instr = q_empty ? '0 : q_rdata.instr;
  assign bus.out_pc    = q_empty ? '0 : q_rdata.pc;

  // Fetch FSM: issues requests, advances fetch_pc and handles redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.redirect_valid) begin
            fetch_pc_q <= bus.redirect_pc;
          end else if (credit_idle) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        REQ: begin
          if (bus.redirect_valid) begin
            fetch_pc_q <= bus.redirect_pc;
            if (ack) begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end else begin
              // Request stays on the port at the old address until acked.
              state_q <= DROP;
            end
          end else if (ack) begin
            fetch_pc_q <= fetch_pc_inc;
            if (credit_after) begin
              imem_addr_q <= fetch_pc_inc;
            end else begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.redirect_valid) begin
            fetch_pc_q <= bus.redirect_pc;
          end
          if (ack) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_prefetch.sv
// Randomised bench for instruction_fetch_prefetch with a stream-level reference model.
module tb_instruction_fetch_prefetch;

  logic clk;
  logic reset;

  instruction_fetch_prefetch_if #(.INSTR_W(16), .PC_W(16)) bus ();

  instruction_fetch_prefetch #(
    .INSTR_W  (16),
    .PC_W     (16),
    .QDEPTH   (4),
    .RESET_PC (16'h0000),
    .PC_STEP  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  int          n_acks   = 0;
  int          mem_wait = 0;
  int          cur_lat  = 0;
  int          lat_fixed = 0;
  bit          lat_rand = 0;
  int          ready_mode = 1;
  bit          prev_req = 0;
  bit          prev_ack = 0;
  logic [15:0] prev_addr = '0;
  logic [15:0] exp_pc = '0;
  logic [15:0] key;
  bit          prev_ffff = 0;
  bit          seen_wrap = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a scrambled function of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] p;
    p = {16'h0, a} * 32'h0000_9E37;
    return p[15:0] ^ key ^ {a[7:0], a[15:8]};
  endfunction

  task automatic reset_model();
    exp_pc    = 16'h0000;
    prev_req  = 0;
    prev_ack  = 0;
    mem_wait  = 0;
    prev_ffff = 0;
  endtask

  // One cycle: memory responder, stimulus, then the decode-stream scoreboard.
  task automatic step(input bit redir, input logic [15:0] rpc);
    @(negedge clk);
    if (bus.imem_req) begin
      if (prev_req && !prev_ack) begin
        mem_wait++;
        check_eq("addr_stable", bus.imem_addr, prev_addr);
      end else begin
        mem_wait = 0;
        cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      end
    end else begin
      mem_wait = 0;
    end
    bus.imem_ack   = bus.imem_req && (mem_wait >= cur_lat);
    bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 16'($urandom);
    if (bus.imem_ack) n_acks++;
    prev_req  = bus.imem_req;
    prev_ack  = bus.imem_ack;
    prev_addr = bus.imem_addr;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir ? rpc : 16'($urandom);
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    if (redir) begin
      $display("REDIRECT pc=%h", rpc);
      exp_pc    = rpc;
      prev_ffff = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      $display("POP pc=%h instr=%h", bus.out_pc, bus.out_instr);
      check_eq("pop_pc", bus.out_pc, exp_pc);
      check_eq("pop_instr", bus.out_instr, mem_word(exp_pc));
      if (exp_pc == 16'h0000 && prev_ffff) seen_wrap = 1;
      prev_ffff = (exp_pc == 16'hFFFF);
      exp_pc    = exp_pc + 16'h0001;
      n_pops++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    #1;
    check_eq("rst_fetch_pc", bus.fetch_pc, 16'h0000);
    check_eq("rst_req", bus.imem_req, 1'b0);
    check_eq("rst_addr", bus.imem_addr, 16'h0000);
    check_eq("rst_valid", bus.out_valid, 1'b0);
    check_eq("rst_instr", bus.out_instr, 16'h0000);
    check_eq("rst_pc", bus.out_pc, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    reset_model();
  endtask

  task automatic wait_pop(input string tag, input int budget);
    int start;
    bit got;
    start = n_pops;
    got   = 0;
    for (int i = 0; i < budget; i++) begin
      step(0, 16'h0);
      if (n_pops > start) begin
        got = 1;
        break;
      end
    end
    check_eq(tag, got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    key                = 16'($urandom);
    reset              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;

    // Zero-latency memory, decode always ready: one instruction per cycle.
    lat_fixed = 0; lat_rand = 0; ready_mode = 1;
    apply_reset();
    step(0, 16'h0);
    check_eq("first_req", bus.imem_req, 1'b1);
    check_eq("first_addr", bus.imem_addr, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      step(0, 16'h0);
      check_eq("stream_valid", bus.out_valid, 1'b1);
    end
    check_eq("stream_pops", n_pops >= 9, 1'b1);

    // Back-pressure: exactly QDEPTH acks, then the request drops.
    ready_mode = 0;
    apply_reset();
    n_acks = 0;
    repeat (12) step(0, 16'h0);
    check_eq("bp_acks", n_acks, 4);
    check_eq("bp_req_low", bus.imem_req, 1'b0);
    check_eq("bp_valid", bus.out_valid, 1'b1);
    n_pops = 0;
    ready_mode = 1;
    repeat (8) step(0, 16'h0);
    check_eq("bp_drain", n_pops >= 5, 1'b1);

    // Redirect while a slow fetch is outstanding: stale response dropped.
    lat_fixed = 3;
    apply_reset();
    step(0, 16'h0);
    check_eq("slow_req", bus.imem_req, 1'b1);
    step(1, 16'h0040);
    step(0, 16'h0);
    check_eq("drop_req", bus.imem_req, 1'b1);
    check_eq("drop_addr", bus.imem_addr, 16'h0000);
    check_eq("drop_fetch_pc", bus.fetch_pc, 16'h0040);
    check_eq("drop_valid", bus.out_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 16'h0);
      if (bus.imem_req && bus.imem_addr == 16'h0040) begin
        found = 1;
        break;
      end
    end
    check_eq("redir_issue", found, 1'b1);
    check_eq("redir_q_empty", bus.out_valid, 1'b0);
    wait_pop("redir_first_pop", 20);

    // Redirect on the same edge as an ack and a pop.
    lat_fixed = 0;
    apply_reset();
    repeat (6) step(0, 16'h0);
    step(1, 16'h1234);
    check_eq("coin_req", bus.imem_req, 1'b1);
    check_eq("coin_valid", bus.out_valid, 1'b1);
    step(0, 16'h0);
    check_eq("coin_flushed", bus.out_valid, 1'b0);
    check_eq("coin_idle", bus.imem_req, 1'b0);
    check_eq("coin_fetch_pc", bus.fetch_pc, 16'h1234);
    wait_pop("coin_pop", 10);

    // PC wrap-around.
    seen_wrap = 0;
    step(1, 16'hFFFF);
    repeat (8) step(0, 16'h0);
    check_eq("wrap", seen_wrap, 1'b1);

    // Asynchronous reset pulse in the middle of a dropped fetch.
    lat_fixed = 3;
    apply_reset();
    step(0, 16'h0);
    step(1, 16'h0200);
    step(0, 16'h0);
    check_eq("mid_drop_addr", bus.imem_addr, 16'h0000);
    #1;
    reset = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    #1;
    check_eq("mid_rst_req", bus.imem_req, 1'b0);
    check_eq("mid_rst_valid", bus.out_valid, 1'b0);
    check_eq("mid_rst_fetch_pc", bus.fetch_pc, 16'h0000);
    #1;
    reset = 1'b1;
    reset_model();
    step(0, 16'h0);
    check_eq("late_ack_ignored", bus.out_valid, 1'b0);
    check_eq("restart_addr", bus.imem_addr, 16'h0000);
    wait_pop("restart_pop", 20);

    // Random latency, random back-pressure, random redirects.
    lat_rand = 1; ready_mode = 2;
    apply_reset();
    n_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        step(1, ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom));
      else
        step(0, 16'h0);
    end
    ready_mode = 1;
    repeat (40) step(0, 16'h0);
    check_eq("rand_progress", n_pops > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
